// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive front end.
package ps2_pkg;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

    localparam logic [1:0] ERR_PARITY  = 2'b01;
    localparam logic [1:0] ERR_STOP    = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    localparam logic [7:0] PFX_EXT = 8'hE0;
    localparam logic [7:0] PFX_BRK = 8'hF0;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } code_t;

endpackage

// File: rtl/ps2_filter.sv
// Two-flop synchroniser plus deglitch filter for one raw PS/2 pin.
// The filtered level only moves after FILT consecutive samples disagree with it.
module ps2_filter #(
    parameter int FILT = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pin_i,
    output logic level_o
);

    localparam int CW = $clog2(FILT + 1);

    logic [1:0]    sync_q;
    logic          level_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q  <= 2'b11;
            level_q <= 1'b1;
            cnt_q   <= CW'(FILT - 1);
        end else begin
            sync_q <= {sync_q[0], pin_i};
            // Down-count disagreeing samples; any agreeing sample restarts the run.
            if (sync_q[1] == level_q) begin
                cnt_q <= CW'(FILT - 1);
            end else if (cnt_q == '0) begin
                level_q <= sync_q[1];
                cnt_q   <= CW'(FILT - 1);
            end else begin
                cnt_q <= cnt_q - CW'(1);
            end
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/ps2_rx_frontend.sv
// PS/2 frame receiver: filtered line sampling, 11-bit frame FSM, E0/F0 prefix folding.
// Define PS2_FIFO_EN for a DEPTH-entry output FIFO; otherwise a single output register.
//
//  state  | meaning
//  IDLE   | waiting for a start bit (dat=0 on clk fall)
//  DATA   | shifting in 8 data bits, LSB first
//  PARITY | checking odd parity over data+parity bit
//  STOP   | expecting stop bit = 1
module ps2_rx_frontend
    import ps2_pkg::*;
#(
    parameter int FILT    = 8,
    parameter int TIMEOUT = 50000,
    parameter int DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] code,
    output logic       ext,
    output logic       brk,
    output logic       code_valid,
    input  logic       code_ready,
    output logic       err_stb,
    output logic [1:0] err_code,
    output logic       overrun
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic clk_f, dat_f, clk_prev_q, strobe;

    ps2_filter #(.FILT(FILT)) u_filt_clk (.clk(clk), .reset_n(reset_n), .pin_i(ps2_clk), .level_o(clk_f));
    ps2_filter #(.FILT(FILT)) u_filt_dat (.clk(clk), .reset_n(reset_n), .pin_i(ps2_dat), .level_o(dat_f));

    assign strobe = clk_prev_q & ~clk_f;

    rx_state_t     state_q, state_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          ext_pend_q, ext_pend_d, brk_pend_q, brk_pend_d;
    logic          push, err_evt;
    logic [1:0]    err_val;
    code_t         push_data;

    always_comb begin
        state_d    = state_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        ext_pend_d = ext_pend_q;
        brk_pend_d = brk_pend_q;
        err_evt    = 1'b0;
        err_val    = ERR_PARITY;
        push       = 1'b0;
        push_data  = '{ext: ext_pend_q, brk: brk_pend_q, code: shift_q};
        tmo_d      = (state_q == IDLE || strobe) ? TW'(TIMEOUT - 1) : tmo_q - TW'(1);

        case (state_q)
            IDLE: if (strobe && !dat_f) begin
                state_d = DATA;
                bit_d   = 3'd0;
            end
            DATA: if (strobe) begin
                shift_d = {dat_f, shift_q[7:1]};
                bit_d   = bit_q + 3'd1;
                if (bit_q == 3'd7) state_d = PARITY;
            end
            PARITY: if (strobe) begin
                if (^{dat_f, shift_q}) begin
                    state_d = STOP;
                end else begin
                    state_d = IDLE;
                    err_evt = 1'b1;
                    err_val = ERR_PARITY;
                end
            end
            STOP: if (strobe) begin
                state_d = IDLE;
                if (!dat_f) begin
                    err_evt = 1'b1;
                    err_val = ERR_STOP;
                end else if (shift_q == PFX_EXT) begin
                    ext_pend_d = 1'b1;
                end else if (shift_q == PFX_BRK) begin
                    brk_pend_d = 1'b1;
                end else begin
                    push       = 1'b1;
                    ext_pend_d = 1'b0;
                    brk_pend_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_q != IDLE && !strobe && tmo_q == '0) begin
            state_d = IDLE;
            err_evt = 1'b1;
            err_val = ERR_TIMEOUT;
        end
        if (err_evt) begin
            ext_pend_d = 1'b0;
            brk_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            bit_q      <= '0;
            shift_q    <= '0;
            tmo_q      <= TW'(TIMEOUT - 1);
            ext_pend_q <= 1'b0;
            brk_pend_q <= 1'b0;
            clk_prev_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            tmo_q      <= tmo_d;
            ext_pend_q <= ext_pend_d;
            brk_pend_q <= brk_pend_d;
            clk_prev_q <= clk_f;
        end
    end

    logic  pop, accept, drop, out_valid;
    code_t out_data;

    assign pop = out_valid & code_ready;

`ifdef PS2_FIFO_EN
    localparam int AW = $clog2(DEPTH);

    code_t         mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic          full;

    assign full   = (cnt_q == (AW+1)'(DEPTH));
    // When full, a same-cycle pop frees the slot being written.
    assign accept = push & (~full | pop);
    assign drop   = push & ~accept;

    always_ff @(posedge clk) begin
        if (accept) mem_q[wr_q] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (accept) wr_q <= wr_q + AW'(1);
            if (pop)    rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + (AW+1)'(accept) - (AW+1)'(pop);
        end
    end

    assign out_valid = (cnt_q != '0);
    assign out_data  = mem_q[rd_q];
`else
    code_t out_q;
    logic  vld_q;

    assign accept = push & (~vld_q | pop);
    assign drop   = push & ~accept;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_q <= '0;
            vld_q <= 1'b0;
        end else if (accept) begin
            out_q <= push_data;
            vld_q <= 1'b1;
        end else if (pop) begin
            vld_q <= 1'b0;
        end
    end

    assign out_valid = vld_q;
    assign out_data  = out_q;
`endif

    logic       err_stb_q, overrun_q;
    logic [1:0] err_code_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            err_stb_q  <= 1'b0;
            err_code_q <= 2'b00;
            overrun_q  <= 1'b0;
        end else begin
            err_stb_q <= err_evt;
            overrun_q <= drop;
            if (err_evt) err_code_q <= err_val;
        end
    end

    assign code       = out_valid ? out_data.code : 8'h00;
    assign ext        = out_valid & out_data.ext;
    assign brk        = out_valid & out_data.brk;
    assign code_valid = out_valid;
    assign err_stb    = err_stb_q;
    assign err_code   = err_code_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_ps2_rx_frontend.sv
// Scoreboard bench for ps2_rx_frontend: drives PS/2 frames, checks codes, errors and overruns.
module tb_ps2_rx_frontend;

    localparam int FILT    = 8;
    localparam int TIMEOUT = 2000;
    localparam int DEPTH   = 4;
    localparam int HALF    = 20;
    localparam int GAP     = 40;

    logic       clk = 1'b0;
    logic       reset_n, ps2_clk, ps2_dat, code_ready;
    logic [7:0] code;
    logic       ext, brk, code_valid, err_stb, overrun;
    logic [1:0] err_code;

    int n_tests = 0;
    int n_fail  = 0;
    int ov_seen = 0;
    int ov_exp  = 0;

    logic [9:0] exp_q [$];
    logic [1:0] err_q [$];

    always #5 clk = ~clk;

    ps2_rx_frontend #(.FILT(FILT), .TIMEOUT(TIMEOUT), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
        .code(code), .ext(ext), .brk(brk), .code_valid(code_valid), .code_ready(code_ready),
        .err_stb(err_stb), .err_code(err_code), .overrun(overrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives the first nbits of a frame (start, 8 data, parity, stop).
    task automatic send_frame(input logic [7:0] b, input bit bad_par = 1'b0,
                              input bit bad_stop = 1'b0, input int nbits = 11);
        logic [10:0] f;
        f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_dat = f[i];
            wait_cyc(HALF);
            ps2_clk = 1'b0;
            wait_cyc(HALF);
            ps2_clk = 1'b1;
        end
        if (nbits == 11) begin
            ps2_dat = 1'b1;
            wait_cyc(GAP);
        end
    endtask

    task automatic exp_code(input logic e, input logic k, input logic [7:0] c);
        exp_q.push_back({e, k, c});
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (code_valid && code_ready) begin
                if (exp_q.size() == 0) chk("code_unexpected", exp_q.size(), 1);
                else chk("code", {ext, brk, code}, exp_q.pop_front());
            end
            if (err_stb) begin
                if (err_q.size() == 0) chk("err_unexpected", err_q.size(), 1);
                else chk("err_code", err_code, err_q.pop_front());
            end
            if (overrun) ov_seen++;
        end
    end

    initial begin
        reset_n    = 1'b0;
        ps2_clk    = 1'b1;
        ps2_dat    = 1'b1;
        code_ready = 1'b1;
        wait_cyc(5);
        chk("rst_valid", code_valid, 0);
        chk("rst_code", code, 0);
        chk("rst_ext", ext, 0);
        chk("rst_brk", brk, 0);
        chk("rst_err_stb", err_stb, 0);
        chk("rst_err_code", err_code, 0);
        chk("rst_overrun", overrun, 0);
        reset_n = 1'b1;
        wait_cyc(10);

        exp_code(0, 0, 8'h1C);
        send_frame(8'h1C);

        exp_code(1, 1, 8'h75);
        send_frame(8'hE0);
        send_frame(8'hF0);
        send_frame(8'h75);

        exp_code(0, 1, 8'h12);
        send_frame(8'hF0);
        send_frame(8'h12);

        // Error must discard the pending E0.
        send_frame(8'hE0);
        err_q.push_back(2'b01);
        send_frame(8'h1C, 1'b1);
        exp_code(0, 0, 8'h1C);
        send_frame(8'h1C);

        err_q.push_back(2'b10);
        send_frame(8'h55, 1'b0, 1'b1);

        exp_code(0, 0, 8'hE1);
        send_frame(8'hE1);

        err_q.push_back(2'b11);
        send_frame(8'h2D, 1'b0, 1'b0, 5);
        wait_cyc(TIMEOUT + 10);
        chk("tmo_err_code", err_code, 2'b11);
        ps2_dat = 1'b1;
        wait_cyc(GAP);
        exp_code(0, 0, 8'h2D);
        send_frame(8'h2D);

        code_ready = 1'b0;
`ifdef PS2_FIFO_EN
        for (int i = 0; i <= DEPTH; i++) begin
            if (i < DEPTH) exp_code(0, 0, 8'h10 + 8'(i));
            send_frame(8'h10 + 8'(i));
        end
        ov_exp++;
        chk("hold_code", code, 8'h10);
`else
        exp_code(0, 0, 8'h1C);
        send_frame(8'h1C);
        send_frame(8'h32);
        ov_exp++;
        chk("hold_code", code, 8'h1C);
        chk("hold_valid", code_valid, 1);
`endif
        code_ready = 1'b1;
        wait_cyc(GAP);

        // Short clk glitch with dat low: must not look like a start bit.
        ps2_dat = 1'b0;
        wait_cyc(HALF);
        ps2_clk = 1'b0;
        wait_cyc(3);
        ps2_clk = 1'b1;
        wait_cyc(HALF);
        ps2_dat = 1'b1;
        wait_cyc(GAP);
        exp_code(0, 0, 8'h5A);
        send_frame(8'h5A);

        // Hold a code, start a frame, then reset mid-frame.
        code_ready = 1'b0;
        send_frame(8'h44);
        chk("pre_rst_valid", code_valid, 1);
        send_frame(8'h3A, 1'b0, 1'b0, 5);
        reset_n = 1'b0;
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        wait_cyc(3);
        chk("midrst_valid", code_valid, 0);
        chk("midrst_code", code, 0);
        chk("midrst_err_code", err_code, 0);
        reset_n    = 1'b1;
        code_ready = 1'b1;
        wait_cyc(GAP);
        exp_code(0, 0, 8'h3A);
        send_frame(8'h3A);

        wait_cyc(100);
        chk("codes_left", exp_q.size(), 0);
        chk("errs_left", err_q.size(), 0);
        chk("overruns", ov_seen, ov_exp);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
